// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// parity-type constants, legal oversampling ratios and the 2-of-3 vote.
package uart_rx_pkg;

    // Frame FSM states; neighbouring states differ in a single bit, matching
    // the encoding style of the transmitter FSM.
    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        START  = 3'b001,
        DATA   = 3'b011,
        PARITY = 3'b010,
        STOP   = 3'b110
    } rx_state_t;

    // Parity type selected by PAR_TYP.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Oversampling ratios the receiver is designed for.
    localparam int unsigned PRESC_8  = 32'd8;
    localparam int unsigned PRESC_16 = 32'd16;
    localparam int unsigned PRESC_32 = 32'd32;

    // 2-of-3 majority vote used to reject single-sample noise.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing and sampling: counts oversampling edges inside a bit,
// captures the line three times around mid-bit and votes on the result.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic               rx_in,
    input  logic [PRESC_W-1:0] prescale,
    output logic               sampled_bit,
    output logic               bit_end,
    output logic               sample_valid
);

    logic [PRESC_W-1:0] edge_cnt_r;
    logic [2:0]         samp_r;
    logic [PRESC_W-1:0] half_s;
    logic [PRESC_W-1:0] last_s;

    // Mid-bit and end-of-bit positions derived from the latched ratio.
    always_comb begin
        half_s = prescale >> 1;
        last_s = prescale - PRESC_W'(1);
    end

    // Edge counter: the start-detect cycle counts as edge 0, so a new frame
    // begins at edge 1; wraps to 0 at the end of each bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_r <= '0;
        end else if (start) begin
            edge_cnt_r <= PRESC_W'(1);
        end else if (en) begin
            if (edge_cnt_r == last_s) begin
                edge_cnt_r <= '0;
            end else begin
                edge_cnt_r <= edge_cnt_r + PRESC_W'(1);
            end
        end else begin
            edge_cnt_r <= '0;
        end
    end

    // Capture the line at edges half-2, half-1 and half of the current bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp_r <= 3'b000;
        end else if (en) begin
            if (edge_cnt_r == half_s - PRESC_W'(2)) begin
                samp_r[0] <= rx_in;
            end else if (edge_cnt_r == half_s - PRESC_W'(1)) begin
                samp_r[1] <= rx_in;
            end else if (edge_cnt_r == half_s) begin
                samp_r[2] <= rx_in;
            end else begin
                samp_r <= samp_r;
            end
        end else begin
            samp_r <= samp_r;
        end
    end

    // Voted bit value plus end-of-bit and vote-ready qualifiers for the FSM.
    always_comb begin
        sampled_bit  = majority3(samp_r[0], samp_r[1], samp_r[2]);
        bit_end      = 1'b0;
        sample_valid = 1'b0;
        if (en) begin
            bit_end      = (edge_cnt_r == last_s);
            sample_valid = (edge_cnt_r > half_s);
        end else begin
            bit_end      = 1'b0;
            sample_valid = 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver frame FSM: start detect, LSB-first deserialisation,
// optional parity check, stop check and one-cycle result pulses.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESC_W-1:0]    Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stop_Err,
    output logic                  Busy
);

    localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_t             state_r;
    logic [BCW-1:0]        bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  par_en_r;
    logic                  par_typ_r;
    logic [PRESC_W-1:0]    presc_r;
    logic                  par_err_r;

    logic                  start_s;
    logic                  en_s;
    logic                  sampled_bit_s;
    logic                  bit_end_s;
    logic                  sample_valid_s;
    logic                  bit_done_s;

    // Mismatch between the received parity bit and the one implied by the data.
    function automatic logic parity_mismatch(input logic [DATA_WIDTH-1:0] data,
                                             input logic par_bit,
                                             input logic par_typ);
        return par_bit ^ (^data) ^ (par_typ == PAR_ODD);
    endfunction

    // Sampler control: load on a start edge in IDLE, run in every other state.
    always_comb begin
        start_s    = 1'b0;
        en_s       = 1'b0;
        bit_done_s = 1'b0;
        if (state_r == IDLE) begin
            start_s = ~RX_IN;
            en_s    = 1'b0;
        end else begin
            start_s = 1'b0;
            en_s    = 1'b1;
        end
        bit_done_s = bit_end_s & sample_valid_s;
    end

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk          (CLK),
        .rst          (RST),
        .en           (en_s),
        .start        (start_s),
        .rx_in        (RX_IN),
        .prescale     (presc_r),
        .sampled_bit  (sampled_bit_s),
        .bit_end      (bit_end_s),
        .sample_valid (sample_valid_s)
    );

    // Frame FSM with registered data, status pulses and Busy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            par_en_r   <= 1'b0;
            par_typ_r  <= PAR_EVEN;
            presc_r    <= '0;
            par_err_r  <= 1'b0;
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            Data_Valid <= 1'b0;
            Par_Err    <= 1'b0;
            Stop_Err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!RX_IN) begin
                        state_r   <= START;
                        Busy      <= 1'b1;
                        par_en_r  <= PAR_EN;
                        par_typ_r <= PAR_TYP;
                        presc_r   <= Prescale;
                        par_err_r <= 1'b0;
                        bit_cnt_r <= '0;
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                START: begin
                    if (bit_done_s) begin
                        if (!sampled_bit_s) begin
                            state_r <= DATA;
                        end else begin
                            // Line bounced back high: not a real start bit.
                            state_r <= IDLE;
                            Busy    <= 1'b0;
                        end
                    end else begin
                        state_r <= START;
                    end
                end
                DATA: begin
                    if (bit_done_s) begin
                        shift_r <= {sampled_bit_s, shift_r[DATA_WIDTH-1:1]};
                        if (bit_cnt_r == BCW'(DATA_WIDTH - 1)) begin
                            bit_cnt_r <= '0;
                            state_r   <= par_en_r ? PARITY : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BCW'(1);
                        end
                    end else begin
                        state_r <= DATA;
                    end
                end
                PARITY: begin
                    if (bit_done_s) begin
                        par_err_r <= parity_mismatch(shift_r, sampled_bit_s, par_typ_r);
                        state_r   <= STOP;
                    end else begin
                        state_r <= PARITY;
                    end
                end
                STOP: begin
                    if (bit_done_s) begin
                        Par_Err  <= par_err_r;
                        Stop_Err <= ~sampled_bit_s;
                        if (!par_err_r && sampled_bit_s) begin
                            Data_Valid <= 1'b1;
                            P_DATA     <= shift_r;
                        end else begin
                            P_DATA <= P_DATA;
                        end
                        state_r <= IDLE;
                        Busy    <= 1'b0;
                    end else begin
                        state_r <= STOP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
